// File: rtl/hazard_addr_pipe.sv
// Register-number and write-control pipeline (Execute/Memory/Writeback) feeding the hazard unit.
// Optional HAZARD_R15_GUARD_EN: compares involving R15 (all-ones) never report a match.
module hazard_addr_pipe #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCSrcD,
  input  logic              CondExE,
  input  logic              FlushE,
  output logic              Match_1E_M,
  output logic              Match_1E_W,
  output logic              Match_2E_M,
  output logic              Match_2E_W,
  output logic              Match_12D_E,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegE,
  output logic              PCWrPendingF,
  output logic              PCSrcW
);

  logic [ADDR_W-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
  logic              RegWriteE, PCSrcE, ValidE;
  logic              PCSrcM, ValidM, ValidW;

  function automatic logic regEq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
`ifdef HAZARD_R15_GUARD_EN
    // R15 reads come from PC+8, so they are never forwarded or stalled on
    return (a == b) && (a != '1) && (b != '1);
`else
    return a == b;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
      ValidE    <= 1'b0;
      WA3M      <= '0;
      RegWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
      ValidM    <= 1'b0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      PCSrcW    <= 1'b0;
      ValidW    <= 1'b0;
    end else begin
      // Flush turns the Execute slot into a bubble; address fields are don't-care then
      RA1E      <= RA1D;
      RA2E      <= RA2D;
      WA3E      <= WA3D;
      RegWriteE <= RegWriteD & ~FlushE;
      MemtoRegE <= MemtoRegD & ~FlushE;
      PCSrcE    <= PCSrcD & ~FlushE;
      ValidE    <= ~FlushE;
      WA3M      <= WA3E;
      RegWriteM <= RegWriteE & CondExE & ValidE;
      PCSrcM    <= PCSrcE & CondExE & ValidE;
      ValidM    <= ValidE;
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      PCSrcW    <= PCSrcM;
      ValidW    <= ValidM;
    end
  end

  // Execute sources against later-stage destinations: index = src*2 + dst (dst 0 = M, 1 = W)
  logic [ADDR_W-1:0] srcE [2];
  logic [ADDR_W-1:0] dstA [2];
  logic              dstV [2];
  logic [3:0]        matchE;

  assign srcE[0] = RA1E;
  assign srcE[1] = RA2E;
  assign dstA[0] = WA3M;
  assign dstA[1] = WA3W;
  assign dstV[0] = ValidM;
  assign dstV[1] = ValidW;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      for (genvar gj = 0; gj < 2; gj++) begin : g_dst
        assign matchE[gi*2+gj] = ValidE & dstV[gj] & regEq(srcE[gi], dstA[gj]);
      end
    end
  endgenerate

  assign Match_1E_M   = matchE[0];
  assign Match_1E_W   = matchE[1];
  assign Match_2E_M   = matchE[2];
  assign Match_2E_W   = matchE[3];
  assign Match_12D_E  = ValidE & (regEq(RA1D, WA3E) | regEq(RA2D, WA3E));
  // Execute term ignores CondExE on purpose: fetch holds until the outcome is known
  assign PCWrPendingF = PCSrcD | (PCSrcE & ValidE) | PCSrcM;

endmodule

// File: tb/tb_hazard_addr_pipe.sv
// Scoreboard bench for hazard_addr_pipe: per-cycle history model predicts every output,
// a separate monitor pops expectations on the falling edge and compares.
module tb_hazard_addr_pipe;
  localparam int AW   = 4;
  localparam int NRND = 600;
  localparam int OFF  = 3;
  localparam int HLEN = NRND + 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [AW-1:0] RA1D = '0, RA2D = '0, WA3D = '0;
  logic          RegWriteD = 1'b0, MemtoRegD = 1'b0, PCSrcD = 1'b0;
  logic          CondExE = 1'b0, FlushE = 1'b0;
  logic          Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic          RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW;

  hazard_addr_pipe #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .FlushE(FlushE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW)
  );

  // One entry per cycle: everything driven into the block during that cycle
  typedef struct packed {
    logic rst, flush, cond, rw, mtr, pcs;
    logic [AW-1:0] ra1, ra2, wa3;
  } cyc_t;

  // Output vector, bit 9 down to 0
  typedef logic [9:0] outv_t;
  string names [10] = '{"PCSrcW", "PCWrPendingF", "MemtoRegE", "RegWriteW", "RegWriteM",
                        "Match_12D_E", "Match_2E_W", "Match_2E_M", "Match_1E_W", "Match_1E_M"};

  cyc_t  hist [HLEN];
  outv_t expQ [$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  bit    stimDone = 1'b0;

  function automatic logic eqr(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef HAZARD_R15_GUARD_EN
    return (a == b) && (a != 4'hF) && (b != 4'hF);
`else
    return a == b;
`endif
  endfunction

  // Instruction issued at t-1 is in E, t-2 in M, t-3 in W. It is live in a stage only
  // if it was not flushed on entry and no reset edge has happened since it was issued.
  function automatic outv_t model(input int t);
    cyc_t  d, e, m, w;
    logic  vE, vM, vW, rwM, pcsM, rwW, pcsW;
    outv_t o;
    d = hist[t+OFF];
    e = hist[t+OFF-1];
    m = hist[t+OFF-2];
    w = hist[t+OFF-3];
    vE   = !e.rst && !e.flush;
    vM   = !m.rst && !m.flush && !e.rst;
    vW   = !w.rst && !w.flush && !m.rst && !e.rst;
    rwM  = m.rw  && e.cond && vM;   // m was in Execute during cycle t-1
    pcsM = m.pcs && e.cond && vM;
    rwW  = w.rw  && m.cond && vW;   // w was in Execute during cycle t-2
    pcsW = w.pcs && m.cond && vW;
    o[0] = vE && vM && eqr(e.ra1, m.wa3);
    o[1] = vE && vW && eqr(e.ra1, w.wa3);
    o[2] = vE && vM && eqr(e.ra2, m.wa3);
    o[3] = vE && vW && eqr(e.ra2, w.wa3);
    o[4] = vE && (eqr(d.ra1, e.wa3) || eqr(d.ra2, e.wa3));
    o[5] = rwM;
    o[6] = rwW;
    o[7] = e.mtr && vE;
    o[8] = d.pcs || (e.pcs && vE) || pcsM;
    o[9] = pcsW;
    return o;
  endfunction

  task automatic issue(input logic rst, input logic flush, input logic cond,
                       input logic rw, input logic mtr, input logic pcs,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                       input logic [AW-1:0] wa3);
    cyc_t c;
    @(posedge clk);
    #1;
    reset = rst; FlushE = flush; CondExE = cond;
    RegWriteD = rw; MemtoRegD = mtr; PCSrcD = pcs;
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    c = '{rst: rst, flush: flush, cond: cond, rw: rw, mtr: mtr, pcs: pcs,
          ra1: ra1, ra2: ra2, wa3: wa3};
    hist[cyc+OFF] = c;
    expQ.push_back(model(cyc));
    cyc++;
  endtask

  task automatic idle(input int n, input logic cond);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, cond, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9);
  endtask

  // Monitor: every cycle the block presents a full output vector
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      outv_t ex, ac;
      ex = expQ.pop_front();
      ac = {PCSrcW, PCWrPendingF, MemtoRegE, RegWriteW, RegWriteM,
            Match_12D_E, Match_2E_W, Match_2E_M, Match_1E_W, Match_1E_M};
      checks++;
      if (ac !== ex) begin
        failures++;
        for (int b = 0; b < 10; b++)
          if (ac[b] !== ex[b])
            $display("FAIL cycle %0d %s: got %b, expected %b", checks - 1, names[9-b], ac[b], ex[b]);
      end else begin
        $display("txn %0d ok outputs=%b", checks - 1, ac);
      end
    end
  end

  initial begin
    for (int i = 0; i < HLEN; i++) hist[i] = '0;
    for (int i = 0; i < OFF; i++) hist[i].rst = 1'b1;

    // Reset held two cycles, then idle with a PC write in Decode
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2, 0);
    // Forward from M: producer of R3 followed by consumer
    issue(0, 0, 0, 1, 0, 0, 4'd0, 4'd1, 4'd3);
    issue(0, 0, 1, 0, 0, 0, 4'd3, 4'd1, 4'd4);
    idle(3, 1);
    // Load-use stall with flush
    issue(0, 0, 1, 1, 1, 0, 4'd0, 4'd1, 4'd5);
    issue(0, 1, 1, 0, 0, 0, 4'd1, 4'd5, 4'd6);
    issue(0, 0, 1, 0, 0, 0, 4'd1, 4'd5, 4'd6);
    idle(3, 1);
    // Condition fail on a register+PC writer
    issue(0, 0, 1, 1, 0, 1, 4'd0, 4'd1, 4'd7);
    idle(4, 0);
    // Conditional PC write taken
    issue(0, 0, 0, 0, 0, 1, 4'd0, 4'd1, 4'd8);
    idle(4, 1);
    // R15 as destination then source
    issue(0, 0, 1, 1, 0, 0, 4'd0, 4'd1, 4'd15);
    issue(0, 0, 1, 0, 0, 0, 4'd15, 4'd15, 4'd2);
    idle(3, 1);
    // Back-to-back flushes, flush together with reset, reset mid-stream
    issue(0, 0, 1, 1, 0, 1, 4'd2, 4'd2, 4'd2);
    issue(0, 1, 1, 1, 0, 1, 4'd2, 4'd2, 4'd2);
    issue(0, 1, 1, 1, 0, 1, 4'd2, 4'd2, 4'd2);
    issue(1, 1, 1, 1, 0, 1, 4'd2, 4'd2, 4'd2);
    issue(0, 0, 1, 1, 0, 1, 4'd2, 4'd2, 4'd2);
    issue(0, 0, 1, 1, 0, 1, 4'd3, 4'd2, 4'd2);
    issue(1, 0, 1, 0, 0, 0, 4'd2, 4'd2, 4'd2);
    idle(4, 1);

    // Random traffic over a small register set so hazards are frequent
    for (int i = 0; i < NRND; i++) begin
      logic [AW-1:0] r [3];
      for (int k = 0; k < 3; k++)
        r[k] = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 3));
      issue($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            $urandom_range(0, 4) == 0, r[0], r[1], r[2]);
    end
    stimDone = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    while (!(stimDone && expQ.size() == 0) && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 5000) begin
      failures++;
      $display("FAIL timeout: got %0d pending expectations, expected 0", expQ.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
